i2c_slave_regs: RTL and testbench
=================================

Name: i2c_slave_regs

Overview:
- I2C target (responder) for the on-chip I2C master's open-drain pins (scl_in/sda_in/scl_oe/sda_oe convention; oe=1 pulls line low).
- 7-bit addressed; exposes a small byte-wide register file to fabric (LED / 7-segment drivers).
- Standard pointer protocol: first written byte sets the register pointer, subsequent bytes write/read with auto-increment.
- Sits on the board I2C bus next to the master for loopback and self-test.

Parameters:
- SLAVE_ADDR, 7'h42, 7-bit bus address matched in the address phase.
- NREGS, 4, number of 8-bit registers; power of two, 2..16.
- PTR_W, 2, pointer width = log2(NREGS).

Ports:
- clk_clk  input  1  system clock; must be at least 20x the SCL frequency.
- reset_reset_n  input  1  asynchronous active-low reset.
- scl_in  input  1  SCL line level (asynchronous).
- sda_in  input  1  SDA line level (asynchronous).
- scl_oe  output  1  SCL pull-low enable; clock stretching is not supported, so this is held 0.
- sda_oe  output  1  SDA pull-low enable (ACK or read data 0).
- regs_out  output  NREGS*8  flat register file; reg k occupies bits [8k+7:8k].
- wr_strobe  output  1  one-clock pulse when a data byte is committed to a register.
- wr_index  output  PTR_W  register index written, valid with wr_strobe.
- busy  output  1  high from addressed START/ACK until STOP or NACK-to-idle.

Behaviour:
- Reset (async assert, sync deassert to clk_clk):
  - sda_oe=0, scl_oe=0, regs_out=0, wr_strobe=0, wr_index=0, busy=0.
  - Pointer=0, FSM=IDLE.
- Line conditioning:
  - scl_in and sda_in each pass through a 2-FF synchronizer, then a 3-sample majority filter.
  - Edge events (scl_rise, scl_fall) and START/STOP are decoded from filtered levels.
  - Detection latency is fixed at 4 clk from the pin change.
  - START: SDA falls while SCL is high. STOP: SDA rises while SCL is high.
- Bit timing:
  - SDA is sampled on scl_rise.
  - sda_oe changes only on the clk cycle in which scl_fall is detected.
- FSM states: IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK.
  - IDLE: on START -> ADDR (bit counter=0).
  - ADDR: shift 8 bits MSB first.
    - After the 8th bit, if addr[7:1]==SLAVE_ADDR -> ADDR_ACK (drive sda_oe=1 on the next scl_fall).
    - Otherwise -> IDLE with sda_oe=0 (NACK, bus ignored until the next START).
  - ADDR_ACK: release SDA on the following scl_fall.
    - R/W=0 -> WR_DATA.
    - R/W=1 -> RD_DATA; the shift register loads reg[pointer] and bit7 is driven on that same scl_fall.
  - WR_DATA: shift 8 bits.
    - First byte after the address is written to the pointer (low PTR_W bits; upper bits ignored).
    - Later bytes write reg[pointer], then pointer = pointer+1 mod NREGS.
    - wr_strobe pulses on the 8th scl_rise, data bytes only. Then -> WR_ACK, which always ACKs.
  - RD_DATA: drive sda_oe = ~bit on each scl_fall. After the 8th bit, release SDA and go to RD_ACK.
  - RD_ACK: sample master ACK on scl_rise.
    - ACK (0): pointer++ mod NREGS, load the next byte, -> RD_DATA.
    - NACK (1): -> IDLE, keeping SDA released.
- Bus events:
  - START in any state (repeated start): -> ADDR. sda_oe released; pointer retained.
  - STOP in any state: -> IDLE, sda_oe=0, busy=0. A partially received byte is discarded, with no write and no wr_strobe.
  - Pointer wrap: NREGS-1 increments to 0 for both writes and reads.
  - START/STOP detection has priority over a bit sample in the same cycle.
- Reset mid-transaction: sda_oe is released immediately (asynchronous), registers are cleared, and no further bus activity occurs until the next START.
- scl_oe is constant 0, kept so that pin-level wiring matches the master.

Decomposition:
- Package i2c_pkg:
  - FSM state enum.
  - Typedef byte_t (8-bit).
  - Constants: SYNC_STAGES=2, FILT_LEN=3, ACK=1'b0, NACK=1'b1.
- Sub-module i2c_line_cond: synchronizer, majority filter, and scl_rise/scl_fall/start_det/stop_det pulse generation. One instance per block.
- The FSM, shift register, pointer and register file stay in i2c_slave_regs.

Test Plan:
- Write: START, 0x84 (addr 0x42, W), 0x01, 0xA5, STOP -> ACK on all three bytes; regs_out[15:8]=0xA5; one wr_strobe with wr_index=1; busy falls after STOP.
- Wrong address: START, 0x86 (0x43, W), 0x00, 0xFF, STOP -> sda_oe never asserted; regs_out unchanged; no wr_strobe.
- Repeated-start read: regs={0x11,0x22,0x33,0x44}; START 0x84, 0x02, Sr 0x85; master ACK, ACK, NACK -> reads 0x33, 0x44, 0x11 (wrap); FSM returns to IDLE after NACK.
- Burst write wrap: START 0x84, 0x03, 0xDE, 0xAD, STOP -> reg3=0xDE, reg0=0xAD; wr_index sequence 3,0.
- Abort: START 0x84, 0x00, 4 bits of 0xF0, then STOP -> reg0 unchanged; no wr_strobe; busy=0.
- Reset mid-read: assert reset_reset_n=0 while sda_oe=1 -> sda_oe=0 in the same cycle; regs_out=0; next full write transaction is ACKed normally.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C register-file target.
package i2c_pkg;

    localparam int   SYNC_STAGES = 2;
    localparam int   FILT_LEN    = 3;
    localparam logic ACK         = 1'b0;
    localparam logic NACK        = 1'b1;

    typedef logic [7:0] byte_t;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ADDR     = 3'd1,
        ST_ADDR_ACK = 3'd2,
        ST_WR_DATA  = 3'd3,
        ST_WR_ACK   = 3'd4,
        ST_RD_DATA  = 3'd5,
        ST_RD_ACK   = 3'd6
    } state_e;

    // Two-out-of-three vote used by the line glitch filter.
    function automatic logic maj3(input logic [2:0] s);
        return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
    endfunction

endpackage

// File: rtl/i2c_line_cond.sv
// Synchronises and filters SCL/SDA, then decodes clock edges and START/STOP.
module i2c_line_cond
    import i2c_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic scl_in,
    input  logic sda_in,
    output logic sda_level,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    logic [SYNC_STAGES-1:0] scl_sync_r;
    logic [SYNC_STAGES-1:0] sda_sync_r;
    logic [FILT_LEN-2:0]    scl_hist_r;
    logic [FILT_LEN-2:0]    sda_hist_r;
    logic                   scl_filt_r;
    logic                   sda_filt_r;
    logic                   scl_prev_r;
    logic                   sda_prev_r;
    logic                   scl_sync_s;
    logic                   sda_sync_s;

    assign scl_sync_s = scl_sync_r[SYNC_STAGES-1];
    assign sda_sync_s = sda_sync_r[SYNC_STAGES-1];

    // Synchroniser, vote history and filtered/previous levels; idle bus reads high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync_r <= {SYNC_STAGES{1'b1}};
            sda_sync_r <= {SYNC_STAGES{1'b1}};
            scl_hist_r <= {(FILT_LEN-1){1'b1}};
            sda_hist_r <= {(FILT_LEN-1){1'b1}};
            scl_filt_r <= 1'b1;
            sda_filt_r <= 1'b1;
            scl_prev_r <= 1'b1;
            sda_prev_r <= 1'b1;
        end else begin
            scl_sync_r <= {scl_sync_r[SYNC_STAGES-2:0], scl_in};
            sda_sync_r <= {sda_sync_r[SYNC_STAGES-2:0], sda_in};
            scl_hist_r <= {scl_hist_r[FILT_LEN-3:0], scl_sync_s};
            sda_hist_r <= {sda_hist_r[FILT_LEN-3:0], sda_sync_s};
            scl_filt_r <= maj3({scl_sync_s, scl_hist_r});
            sda_filt_r <= maj3({sda_sync_s, sda_hist_r});
            scl_prev_r <= scl_filt_r;
            sda_prev_r <= sda_filt_r;
        end
    end

    // SDA edges only count as bus conditions while SCL stays high across them.
    always_comb begin
        sda_level = sda_filt_r;
        scl_rise  = scl_filt_r & ~scl_prev_r;
        scl_fall  = ~scl_filt_r & scl_prev_r;
        start_det = scl_filt_r & scl_prev_r & sda_prev_r & ~sda_filt_r;
        stop_det  = scl_filt_r & scl_prev_r & ~sda_prev_r & sda_filt_r;
    end

endmodule

// File: rtl/i2c_slave_regs.sv
// I2C target exposing NREGS byte registers with an auto-incrementing pointer.
module i2c_slave_regs
    import i2c_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR = 7'h42,
    parameter int         NREGS      = 4,
    parameter int         PTR_W      = 2
) (
    input  logic               clk_clk,
    input  logic               reset_reset_n,
    input  logic               scl_in,
    input  logic               sda_in,
    output logic               scl_oe,
    output logic               sda_oe,
    output logic [NREGS*8-1:0] regs_out,
    output logic               wr_strobe,
    output logic [PTR_W-1:0]   wr_index,
    output logic               busy
);

    logic [1:0]       rst_sync_r;
    logic             rst_n_s;
    logic             sda_lvl_s;
    logic             scl_rise_s;
    logic             scl_fall_s;
    logic             start_det_s;
    logic             stop_det_s;

    state_e           state_r;
    logic [3:0]       bit_cnt_r;
    byte_t            shift_r;
    logic [PTR_W-1:0] ptr_r;
    byte_t            regs_r [NREGS];
    logic             sda_oe_r;
    logic             wr_strobe_r;
    logic [PTR_W-1:0] wr_index_r;
    logic             busy_r;
    logic             ack_on_r;
    logic             first_byte_r;
    logic             rw_r;

    byte_t            rx_byte_s;
    logic             last_bit_s;
    logic [PTR_W-1:0] ptr_inc_s;
    byte_t            rd_byte_s;
    byte_t            rd_next_s;

    // Reset asserts immediately but releases in step with clk_clk.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            rst_sync_r <= 2'b00;
        end else begin
            rst_sync_r <= {rst_sync_r[0], 1'b1};
        end
    end
    assign rst_n_s = rst_sync_r[1];

    i2c_line_cond u_line_cond (
        .clk       (clk_clk),
        .rst_n     (rst_n_s),
        .scl_in    (scl_in),
        .sda_in    (sda_in),
        .sda_level (sda_lvl_s),
        .scl_rise  (scl_rise_s),
        .scl_fall  (scl_fall_s),
        .start_det (start_det_s),
        .stop_det  (stop_det_s)
    );

    // Byte assembly and pointer arithmetic shared by the FSM.
    always_comb begin
        rx_byte_s  = {shift_r[6:0], sda_lvl_s};
        last_bit_s = (bit_cnt_r == 4'd7);
        ptr_inc_s  = ptr_r + PTR_W'(1);
        rd_byte_s  = regs_r[ptr_r];
        rd_next_s  = regs_r[ptr_inc_s];
    end

    // Protocol FSM; bus conditions override any bit event in the same cycle.
    always_ff @(posedge clk_clk or negedge rst_n_s) begin
        if (!rst_n_s) begin
            state_r      <= ST_IDLE;
            bit_cnt_r    <= 4'd0;
            shift_r      <= 8'h00;
            ptr_r        <= '0;
            sda_oe_r     <= 1'b0;
            wr_strobe_r  <= 1'b0;
            wr_index_r   <= '0;
            busy_r       <= 1'b0;
            ack_on_r     <= 1'b0;
            first_byte_r <= 1'b0;
            rw_r         <= 1'b0;
            for (int k = 0; k < NREGS; k++) begin
                regs_r[k] <= 8'h00;
            end
        end else begin
            wr_strobe_r <= 1'b0;
            if (stop_det_s) begin
                state_r   <= ST_IDLE;
                sda_oe_r  <= 1'b0;
                busy_r    <= 1'b0;
                bit_cnt_r <= 4'd0;
                ack_on_r  <= 1'b0;
            end else if (start_det_s) begin
                state_r   <= ST_ADDR;
                sda_oe_r  <= 1'b0;
                bit_cnt_r <= 4'd0;
                ack_on_r  <= 1'b0;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        sda_oe_r <= 1'b0;
                        busy_r   <= 1'b0;
                    end
                    ST_ADDR: begin
                        if (scl_rise_s) begin
                            shift_r   <= rx_byte_s;
                            bit_cnt_r <= bit_cnt_r + 4'd1;
                            if (last_bit_s) begin
                                bit_cnt_r <= 4'd0;
                                if (rx_byte_s[7:1] == SLAVE_ADDR) begin
                                    state_r      <= ST_ADDR_ACK;
                                    rw_r         <= rx_byte_s[0];
                                    busy_r       <= 1'b1;
                                    first_byte_r <= 1'b1;
                                    ack_on_r     <= 1'b0;
                                end else begin
                                    state_r <= ST_IDLE;
                                    busy_r  <= 1'b0;
                                end
                            end
                        end
                    end
                    ST_ADDR_ACK: begin
                        // First fall drives the ACK, second fall ends the ACK bit.
                        if (scl_fall_s) begin
                            if (!ack_on_r) begin
                                sda_oe_r <= ~ACK;
                                ack_on_r <= 1'b1;
                            end else begin
                                ack_on_r  <= 1'b0;
                                bit_cnt_r <= 4'd0;
                                if (rw_r) begin
                                    state_r  <= ST_RD_DATA;
                                    sda_oe_r <= ~rd_byte_s[7];
                                    shift_r  <= {rd_byte_s[6:0], 1'b0};
                                end else begin
                                    state_r  <= ST_WR_DATA;
                                    sda_oe_r <= 1'b0;
                                end
                            end
                        end
                    end
                    ST_WR_DATA: begin
                        if (scl_rise_s) begin
                            shift_r   <= rx_byte_s;
                            bit_cnt_r <= bit_cnt_r + 4'd1;
                            if (last_bit_s) begin
                                bit_cnt_r <= 4'd0;
                                state_r   <= ST_WR_ACK;
                                ack_on_r  <= 1'b0;
                                if (first_byte_r) begin
                                    ptr_r        <= rx_byte_s[PTR_W-1:0];
                                    first_byte_r <= 1'b0;
                                end else begin
                                    regs_r[ptr_r] <= rx_byte_s;
                                    wr_strobe_r   <= 1'b1;
                                    wr_index_r    <= ptr_r;
                                    ptr_r         <= ptr_inc_s;
                                end
                            end
                        end
                    end
                    ST_WR_ACK: begin
                        if (scl_fall_s) begin
                            if (!ack_on_r) begin
                                sda_oe_r <= ~ACK;
                                ack_on_r <= 1'b1;
                            end else begin
                                sda_oe_r  <= 1'b0;
                                ack_on_r  <= 1'b0;
                                bit_cnt_r <= 4'd0;
                                state_r   <= ST_WR_DATA;
                            end
                        end
                    end
                    ST_RD_DATA: begin
                        if (scl_fall_s) begin
                            if (bit_cnt_r == 4'd8) begin
                                sda_oe_r  <= 1'b0;
                                bit_cnt_r <= 4'd0;
                                state_r   <= ST_RD_ACK;
                            end else begin
                                sda_oe_r <= ~shift_r[7];
                                shift_r  <= {shift_r[6:0], 1'b0};
                            end
                        end else if (scl_rise_s) begin
                            bit_cnt_r <= bit_cnt_r + 4'd1;
                        end
                    end
                    ST_RD_ACK: begin
                        // Next byte is staged here and its MSB goes out on the coming fall.
                        if (scl_rise_s) begin
                            if (sda_lvl_s == NACK) begin
                                state_r <= ST_IDLE;
                                busy_r  <= 1'b0;
                            end else begin
                                ptr_r     <= ptr_inc_s;
                                shift_r   <= rd_next_s;
                                bit_cnt_r <= 4'd0;
                                state_r   <= ST_RD_DATA;
                            end
                        end
                    end
                    default: begin
                        state_r  <= ST_IDLE;
                        sda_oe_r <= 1'b0;
                        busy_r   <= 1'b0;
                    end
                endcase
            end
        end
    end

    for (genvar k = 0; k < NREGS; k++) begin : g_regs
        assign regs_out[8*k +: 8] = regs_r[k];
    end

    assign scl_oe    = 1'b0;
    assign sda_oe    = sda_oe_r;
    assign wr_strobe = wr_strobe_r;
    assign wr_index  = wr_index_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_i2c_slave_regs.sv
// Directed bench: bit-banged I2C master with a write scoreboard on wr_strobe.
module tb_i2c_slave_regs;

    localparam int Q = 10;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        scl_m;
    logic        sda_m;
    logic        scl_line;
    logic        sda_line;
    logic        scl_oe;
    logic        sda_oe;
    logic [31:0] regs_out;
    logic        wr_strobe;
    logic [1:0]  wr_index;
    logic        busy;

    int          checks = 0;
    int          failures = 0;
    int          oe_cnt = 0;
    logic [9:0]  exp_q [$];
    logic [9:0]  mon_e;

    assign scl_line = scl_m & ~scl_oe;
    assign sda_line = sda_m & ~sda_oe;

    i2c_slave_regs dut (
        .clk_clk       (clk),
        .reset_reset_n (rst_n),
        .scl_in        (scl_line),
        .sda_in        (sda_line),
        .scl_oe        (scl_oe),
        .sda_oe        (sda_oe),
        .regs_out      (regs_out),
        .wr_strobe     (wr_strobe),
        .wr_index      (wr_index),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    // Scoreboard monitor: every write strobe must match the next queued expectation.
    always @(negedge clk) begin
        if (sda_oe) oe_cnt++;
        if (wr_strobe) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL wr_unexpected actual idx=%0d data=%02h required none", wr_index, regs_out[8*wr_index +: 8]);
            end else begin
                mon_e = exp_q.pop_front();
                if (wr_index !== mon_e[9:8] || regs_out[8*mon_e[9:8] +: 8] !== mon_e[7:0]) begin
                    failures++;
                    $display("FAIL wr_commit actual idx=%0d data=%02h required idx=%0d data=%02h",
                             wr_index, regs_out[8*mon_e[9:8] +: 8], mon_e[9:8], mon_e[7:0]);
                end
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic i2c_start();
        sda_m = 1'b0; wait_clk(Q);
        scl_m = 1'b0; wait_clk(Q);
    endtask

    task automatic i2c_rstart();
        sda_m = 1'b1; wait_clk(Q);
        scl_m = 1'b1; wait_clk(Q);
        sda_m = 1'b0; wait_clk(Q);
        scl_m = 1'b0; wait_clk(Q);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; wait_clk(Q);
        scl_m = 1'b1; wait_clk(Q);
        sda_m = 1'b1; wait_clk(2*Q);
    endtask

    task automatic wbit(input logic b);
        sda_m = b;    wait_clk(Q);
        scl_m = 1'b1; wait_clk(2*Q);
        scl_m = 1'b0; wait_clk(Q);
    endtask

    task automatic rbit(output logic b);
        sda_m = 1'b1; wait_clk(Q);
        scl_m = 1'b1; wait_clk(Q);
        b = sda_line; wait_clk(Q);
        scl_m = 1'b0; wait_clk(Q);
    endtask

    task automatic wbyte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) wbit(d[i]);
        rbit(ack);
    endtask

    task automatic rbyte(output logic [7:0] d, input logic ack);
        logic b;
        d = 8'h00;
        for (int i = 0; i < 8; i++) begin
            rbit(b);
            d = {d[6:0], b};
        end
        wbit(ack);
    endtask

    // Writes a pointer then data bytes, checking every ACK and queuing expected commits.
    task automatic write_txn(input string name, input logic [7:0] ptr, input logic [7:0] data [], input bit do_stop);
        logic       ack;
        logic [1:0] idx;
        i2c_start();
        wbyte(8'h84, ack); chk({name, "_addr_ack"}, {31'd0, ack}, 32'd0);
        wbyte(ptr, ack);   chk({name, "_ptr_ack"}, {31'd0, ack}, 32'd0);
        idx = ptr[1:0];
        foreach (data[i]) begin
            exp_q.push_back({idx, data[i]});
            idx = idx + 2'd1;
            wbyte(data[i], ack); chk({name, "_data_ack"}, {31'd0, ack}, 32'd0);
        end
        if (do_stop) i2c_stop();
    endtask

    initial begin
        logic       ack;
        logic       b;
        logic [7:0] rd;
        logic [7:0] d1 [];
        logic [7:0] d4 [];
        logic [7:0] dw [];
        logic [7:0] d0 [];
        int         waited;

        rst_n = 1'b0; scl_m = 1'b1; sda_m = 1'b1;
        wait_clk(5);
        chk("rst_regs", regs_out, 32'h0);
        chk("rst_sda_oe", {31'd0, sda_oe}, 32'd0);
        chk("rst_scl_oe", {31'd0, scl_oe}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_strobe", {31'd0, wr_strobe}, 32'd0);
        chk("rst_index", {30'd0, wr_index}, 32'd0);
        rst_n = 1'b1;
        wait_clk(10);

        // Single write to reg1
        d1 = new[1]; d1[0] = 8'hA5;
        write_txn("t1", 8'h01, d1, 1'b0);
        chk("t1_busy_active", {31'd0, busy}, 32'd1);
        i2c_stop();
        wait_clk(5);
        chk("t1_busy_after_stop", {31'd0, busy}, 32'd0);
        chk("t1_reg1", {24'd0, regs_out[15:8]}, 32'hA5);

        // Wrong address is ignored entirely
        oe_cnt = 0;
        i2c_start();
        wbyte(8'h86, ack); chk("t2_addr_nack", {31'd0, ack}, 32'd1);
        wbyte(8'h00, ack);
        wbyte(8'hFF, ack);
        i2c_stop();
        chk("t2_sda_oe_never", oe_cnt, 32'd0);
        chk("t2_regs", regs_out, 32'h0000A500);
        chk("t2_busy", {31'd0, busy}, 32'd0);

        // Preload, then repeated-start read from pointer 2 with wrap
        d4 = new[4]; d4[0] = 8'h11; d4[1] = 8'h22; d4[2] = 8'h33; d4[3] = 8'h44;
        write_txn("pre", 8'h00, d4, 1'b1);
        chk("pre_regs", regs_out, 32'h44332211);
        d0 = new[0];
        write_txn("t3", 8'h02, d0, 1'b0);
        i2c_rstart();
        wbyte(8'h85, ack); chk("t3_rd_addr_ack", {31'd0, ack}, 32'd0);
        rbyte(rd, 1'b0); chk("t3_rd0", {24'd0, rd}, 32'h33);
        rbyte(rd, 1'b0); chk("t3_rd1", {24'd0, rd}, 32'h44);
        rbyte(rd, 1'b1); chk("t3_rd2_wrap", {24'd0, rd}, 32'h11);
        chk("t3_busy_after_nack", {31'd0, busy}, 32'd0);
        chk("t3_sda_released", {31'd0, sda_oe}, 32'd0);
        i2c_stop();

        // Burst write across the wrap point
        dw = new[2]; dw[0] = 8'hDE; dw[1] = 8'hAD;
        write_txn("t4", 8'h03, dw, 1'b1);
        chk("t4_regs", regs_out, 32'hDE3322AD);

        // Aborted partial byte
        write_txn("t5", 8'h00, d0, 1'b0);
        for (int i = 0; i < 4; i++) wbit(1'b1);
        i2c_stop();
        wait_clk(5);
        chk("t5_regs", regs_out, 32'hDE3322AD);
        chk("t5_busy", {31'd0, busy}, 32'd0);

        // Reset while the target drives a 0 data bit (reg0 = 0xAD, bit6 = 0)
        write_txn("t6", 8'h00, d0, 1'b0);
        i2c_rstart();
        wbyte(8'h85, ack); chk("t6_rd_addr_ack", {31'd0, ack}, 32'd0);
        rbit(b); chk("t6_rd_bit7", {31'd0, b}, 32'd1);
        waited = 0;
        while (!sda_oe && waited < 40) begin
            wait_clk(1);
            waited++;
        end
        chk("t6_sda_oe_driven", {31'd0, sda_oe}, 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("t6_sda_oe_async", {31'd0, sda_oe}, 32'd0);
        chk("t6_regs_cleared", regs_out, 32'h0);
        chk("t6_busy_cleared", {31'd0, busy}, 32'd0);
        scl_m = 1'b1; sda_m = 1'b1;
        wait_clk(5);
        rst_n = 1'b1;
        wait_clk(10);
        d1[0] = 8'h5A;
        write_txn("t6w", 8'h01, d1, 1'b1);
        chk("t6_regs_after", regs_out, 32'h00005A00);

        wait_clk(5);
        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
